// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four BCD digits (sec0, sec1, min0, min1)
// onto a 4-digit common-anode 7-segment display. Anodes, segments and dp are
// active-low. All four digits are snapshotted together at the start of each
// scan frame so a mid-frame count change never shows a torn display.
// Optional feature macro: DP_BLINK_EN (blinking colon dp on slot 2).
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
`ifdef DP_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 250
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] sec0,
  input  logic [31:0] sec1,
  input  logic [31:0] min0,
  input  logic [31:0] min1,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic          tick;
  logic [31:0]   snap_sec1;
  logic [31:0]   snap_min0;
  logic [31:0]   snap_min1;
  logic [31:0]   cur_digit;

  // Active-low BCD decode; any value above 9 (full 32-bit compare) is a dash.
  function automatic logic [6:0] decode(input logic [31:0] v);
    case (v)
      32'd0:   decode = 7'b1000000;
      32'd1:   decode = 7'b1111001;
      32'd2:   decode = 7'b0100100;
      32'd3:   decode = 7'b0110000;
      32'd4:   decode = 7'b0011001;
      32'd5:   decode = 7'b0010010;
      32'd6:   decode = 7'b0000010;
      32'd7:   decode = 7'b1111000;
      32'd8:   decode = 7'b0000000;
      32'd9:   decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign tick     = en && (cnt == CW'(REFRESH_DIV - 1));
  assign idx_next = idx + 2'd1;

  // Select the digit for the slot about to be shown. Slot 0 is only ever
  // displayed on the capture edge, so it reads sec0 live and needs no
  // snapshot register of its own.
  always_comb begin
    cur_digit = sec0;
    case (idx_next)
      2'd0:    cur_digit = sec0;
      2'd1:    cur_digit = snap_sec1;
      2'd2:    cur_digit = snap_min0;
      default: cur_digit = snap_min1;
    endcase
  end

  // Prescaler, slot rotation, frame snapshot and registered an/seg outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= 2'd3;
      snap_sec1 <= '0;
      snap_min0 <= '0;
      snap_min1 <= '0;
      an        <= '1;
      seg       <= '1;
    end else if (!en) begin
      cnt <= '0;
      an  <= '1;
      seg <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= idx_next;
        if (idx_next == 2'd0) begin
          snap_sec1 <= sec1;
          snap_min0 <= min0;
          snap_min1 <= min1;
        end
        an  <= ~(4'b0001 << idx_next);
        seg <= decode(cur_digit);
      end
    end
  end

`ifdef DP_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] fcnt;
  logic          phase;

  // Frame counter: fcnt holds frames started in the current half-period, so
  // the phase flips at the start of frame BLINK_FRAMES+1, 2*BLINK_FRAMES+1, ...
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt  <= '0;
      phase <= 1'b0;
      dp    <= 1'b1;
    end else if (!en) begin
      dp <= 1'b1;
    end else if (tick) begin
      if (idx_next == 2'd0) begin
        if (fcnt == FW'(BLINK_FRAMES)) begin
          fcnt  <= FW'(1);
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
      dp <= ~((idx_next == 2'd2) && phase);
    end
  end
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
// Define DP_BLINK_EN to also build and check the blinking colon (BLINK_FRAMES=2).
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] sec0, sec1, min0, min1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp;
  int n_err;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;

`ifdef DP_BLINK_EN
  seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
`else
  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
`endif
    .clk(clk), .reset(reset), .en(en),
    .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
    .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles, release on a falling edge with en=1.
  task automatic do_reset();
    reset = 1'b0;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1;
    sec0 = 32'd3; sec1 = 32'd5; min0 = 32'd9; min1 = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_cmp++;
      if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got an=%b seg=%b dp=%b, want 1111 1111111 1", i, an, seg, dp);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      n_cmp++;
      if (an !== 4'b1111 || seg !== BLANK) begin
        n_err++;
        $display("FAIL initial_blank[edge %0d]: got an=%b seg=%b, want 1111 1111111", i, an, seg);
      end
    end
    step(5);
    // Mid-scan, between edges: reset must take effect without a clock edge.
    reset = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [5];
    logic [6:0] exp_seg [5];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_seg = '{S3, S5, S9, S0, S3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4);
      n_cmp++;
      if (an !== exp_an[i] || seg !== exp_seg[i] || dp !== 1'b1) begin
        n_err++;
        $display("FAIL scan[%0d]: got an=%b seg=%b dp=%b, want %b %b 1", i, an, seg, dp, exp_an[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_tearing();
    do_reset();
    step(8);
    min1 = 32'd1;
    step(8);
    n_cmp++;
    if (an !== 4'b0111 || seg !== S0) begin
      n_err++;
      $display("FAIL tearing_old: got an=%b seg=%b, want 0111 %b", an, seg, S0);
    end
    step(16);
    n_cmp++;
    if (an !== 4'b0111 || seg !== S1) begin
      n_err++;
      $display("FAIL tearing_new: got an=%b seg=%b, want 0111 %b", an, seg, S1);
    end
    min1 = 32'd0;
  endtask

  task automatic test_invalid();
    do_reset();
    sec1 = 32'd12;
    step(8);
    n_cmp++;
    if (an !== 4'b1101 || seg !== DASH) begin
      n_err++;
      $display("FAIL invalid_12: got an=%b seg=%b, want 1101 %b", an, seg, DASH);
    end
    sec1 = 32'h00000100;
    step(16);
    n_cmp++;
    if (an !== 4'b1101 || seg !== DASH) begin
      n_err++;
      $display("FAIL invalid_wide: got an=%b seg=%b, want 1101 %b", an, seg, DASH);
    end
    sec1 = 32'd9;
    step(16);
    n_cmp++;
    if (an !== 4'b1101 || seg !== S9) begin
      n_err++;
      $display("FAIL valid_9: got an=%b seg=%b, want 1101 %b", an, seg, S9);
    end
    sec1 = 32'd5;
  endtask

  task automatic test_en();
    do_reset();
    step(8);
    en = 1'b0;
    step(1);
    n_cmp++;
    if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
      n_err++;
      $display("FAIL en_blank: got an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
    end
    step(5);
    n_cmp++;
    if (an !== 4'b1111 || seg !== BLANK) begin
      n_err++;
      $display("FAIL en_frozen: got an=%b seg=%b, want 1111 1111111", an, seg);
    end
    en = 1'b1;
    step(3);
    n_cmp++;
    if (an !== 4'b1111) begin
      n_err++;
      $display("FAIL en_resume_wait: got an=%b, want 1111", an);
    end
    step(1);
    n_cmp++;
    if (an !== 4'b1011 || seg !== S9) begin
      n_err++;
      $display("FAIL en_resume: got an=%b seg=%b, want 1011 %b", an, seg, S9);
    end
    // Drop en exactly on the cycle a tick would fire: idx must not advance.
    step(3);
    en = 1'b0;
    step(1);
    n_cmp++;
    if (an !== 4'b1111 || seg !== BLANK) begin
      n_err++;
      $display("FAIL en_vs_tick_blank: got an=%b seg=%b, want 1111 1111111", an, seg);
    end
    en = 1'b1;
    step(4);
    n_cmp++;
    if (an !== 4'b0111 || seg !== S0) begin
      n_err++;
      $display("FAIL en_vs_tick_idx: got an=%b seg=%b, want 0111 %b", an, seg, S0);
    end
  endtask

  task automatic test_dp();
    logic exp_dp;
    do_reset();
    step(12);
    for (int k = 1; k <= 8; k++) begin
`ifdef DP_BLINK_EN
      exp_dp = (((k - 1) / 2) % 2 == 1) ? 1'b0 : 1'b1;
`else
      exp_dp = 1'b1;
`endif
      n_cmp++;
      if (an !== 4'b1011 || dp !== exp_dp) begin
        n_err++;
        $display("FAIL dp_slot2[frame %0d]: got an=%b dp=%b, want 1011 %b", k, an, dp, exp_dp);
      end
      step(4);
      n_cmp++;
      if (an !== 4'b0111 || dp !== 1'b1) begin
        n_err++;
        $display("FAIL dp_slot3[frame %0d]: got an=%b dp=%b, want 0111 1", k, an, dp);
      end
      step(12);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    en    = 1'b0;
    sec0 = '0; sec1 = '0; min0 = '0; min1 = '0;
    test_reset();
    test_scan();
    test_tearing();
    test_invalid();
    test_en();
    test_dp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish, want finish");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the clock counter's four digit outputs: sec0, sec1, min0 and min1.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display. Anodes and segments are active-low.
- Snapshots all four digits once per scan frame, so a count that changes mid-frame never shows as a torn mix of old and new digits.
- Owns the refresh prescaler, the digit rotation and the BCD-to-segment decode.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥2. Benches use 4.
- BLINK_FRAMES, 250: scan frames per dp blink half-period. Used only with DP_BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- en  in  1  display enable; 0 blanks the display and freezes scanning.
- sec0  in  32  seconds units digit from the clock counter.
- sec1  in  32  seconds tens digit.
- min0  in  32  minutes units digit.
- min1  in  32  minutes tens digit.
- an  out  4  anode selects, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset values (reset=0, applied immediately without waiting for a clock edge):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Prescaler cnt=0, idx=3, snapshot registers=0, blink phase=0.
- Prescaler:
  - While en=1, cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted in the cycle where cnt==REFRESH_DIV-1.
- Slot rotation on tick: idx_next=(idx+1) mod 4.
  - idx 0 shows sec0, 1 shows sec1, 2 shows min0, 3 shows min1.
- Snapshot:
  - On a tick where idx_next==0, all four inputs are captured together into the snapshot registers.
  - Inputs are ignored at every other time.
- Outputs are registered and update on the tick edge:
  - an <= ~(4'b0001<<idx_next).
  - seg <= decode(digit of slot idx_next).
  - For idx_next==0 the decode uses the value being captured on that same edge.
- Latency and initial blank:
  - First lit digit (sec0) appears REFRESH_DIV cycles after reset deasserts with en=1.
  - A full frame takes 4*REFRESH_DIV cycles.
  - Between reset release and the first tick, outputs hold their reset values.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Invalid values:
  - Any 32-bit value >9 displays a dash, seg=0111111.
  - The full 32-bit width is compared; the value is never truncated to a nibble.
- en handling:
  - en=0: on the next edge an=1111, seg=1111111, dp=1; cnt is held at 0; idx and snapshot are held.
  - en rising: counting resumes from cnt=0, and the next tick shows slot idx+1.
- Simultaneous en=0 and tick: en wins; idx does not advance.
- Reset mid-frame: all state returns to reset values; the partial frame is discarded.

Optional Feature:
- Macro: DP_BLINK_EN.
- Defined:
  - A frame counter toggles the blink phase every BLINK_FRAMES frames, counted on each idx_next==0 tick.
  - dp <= 0 (lit) while idx_next==2, phase=1 and en=1. This is the colon position between minutes and seconds.
  - Otherwise dp=1.
- Undefined: no frame counter is built, and dp is constant 1.

Test Plan:
- Reset hold: reset=0 with inputs 3/5/9/0 and toggling clk -> an=1111, seg=1111111, dp=1 throughout. Asserting reset between clock edges mid-scan forces these values with no clk edge.
- Normal scan, REFRESH_DIV=4, en=1, sec0=3, sec1=5, min0=9, min1=0 -> first tick 4 cycles after release, then one step every 4 cycles:
  - an=1110, seg=0110000.
  - an=1101, seg=0010010.
  - an=1011, seg=0010000.
  - an=0111, seg=1000000.
  - Then wraps to an=1110.
- Tearing: change min1 from 0 to 1 while idx=1 -> the idx=3 slot still shows 1000000. The next frame shows 1111001.
- Invalid: sec1=12 -> seg=0111111 in slot 1. sec1=32'h00000100 -> seg=0111111, not the "0" pattern.
- en: drop en while idx=1 -> next edge an=1111, seg=1111111, idx held. Raise en -> 4 cycles later an=1011 (slot 2).
- DP_BLINK_EN with BLINK_FRAMES=2:
  - dp=0 only during slot 2 in frames 3-4, 7-8, ...
  - dp=1 in frames 1-2, 5-6, ...
  - Without the macro, dp=1 always.
